// File: rtl/rc6_pkg.sv
// Shared RC6 constants, enums and the pair-role decode used by the key path.
package rc6_pkg;

  localparam int unsigned RC6_W      = 32;
  localparam int unsigned RC6_ROUNDS = 20;
  localparam int unsigned RC6_PAIRS  = RC6_ROUNDS + 2;

  typedef enum logic [1:0] {
    PRE   = 2'd0,
    ROUND = 2'd1,
    POST  = 2'd2
  } key_phase_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } seq_state_e;

  // Role of a ROM pair, decoded from its index only (direction-independent).
  function automatic key_phase_e pair_phase(input logic [4:0] idx);
    if (idx == 5'd0) return PRE;
    if (idx == 5'(RC6_PAIRS - 1)) return POST;
    return ROUND;
  endfunction

endpackage

// File: rtl/rc6_key_sequencer.sv
// Walks the RC6 round-key ROM forward (encrypt) or reverse (decrypt) and
// presents one S[2i]/S[2i+1] pair per valid/ready handshake.
module rc6_key_sequencer
  import rc6_pkg::*;
#(
  parameter int unsigned W     = RC6_W,
  parameter int unsigned PAIRS = RC6_PAIRS
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           decrypt,
  input  logic           abort,
  output logic [4:0]     rom_addr,
  input  logic [2*W-1:0] rom_q,
  output logic           key_valid,
  input  logic           key_ready,
  output logic [W-1:0]   key_a,
  output logic [W-1:0]   key_b,
  output logic [4:0]     key_round,
  output logic [1:0]     key_phase,
  output logic           busy,
  output logic           done
);

  localparam logic [4:0] LAST    = 5'(PAIRS - 1);
  localparam logic [4:0] END_CNT = 5'(PAIRS);

  seq_state_e state;
  logic [4:0] cnt;
  logic       dir;

  // ROM address depends only on the count and the latched direction registers.
  assign rom_addr = dir ? (LAST - cnt) : cnt;

  // Sequencer FSM, pair counter and registered key outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dir       <= 1'b0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      key_a     <= '0;
      key_b     <= '0;
      key_round <= '0;
      key_phase <= PRE;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        // abort beats any handshake in the same cycle
        state     <= IDLE;
        cnt       <= '0;
        key_valid <= 1'b0;
        busy      <= 1'b0;
        key_a     <= '0;
        key_b     <= '0;
        key_round <= '0;
        key_phase <= PRE;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              dir   <= decrypt;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= LOAD;
            end
          end
          LOAD: begin
            key_a     <= rom_q[W-1:0];
            key_b     <= rom_q[2*W-1:W];
            key_round <= rom_addr;
            key_phase <= pair_phase(rom_addr);
            key_valid <= 1'b1;
            cnt       <= 5'd1;
            state     <= RUN;
          end
          RUN: begin
            if (key_valid && key_ready) begin
              if (cnt < END_CNT) begin
                key_a     <= rom_q[W-1:0];
                key_b     <= rom_q[2*W-1:W];
                key_round <= rom_addr;
                key_phase <= pair_phase(rom_addr);
                cnt       <= cnt + 5'd1;
              end else begin
                key_valid <= 1'b0;
                done      <= 1'b1;
                busy      <= 1'b0;
                cnt       <= '0;
                state     <= IDLE;
              end
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc6_key_sequencer.sv
// Self-checking bench for rc6_key_sequencer with a behavioural ROM and pair-order model.
module tb_rc6_key_sequencer;

  localparam int NP = 22;

  logic        clk = 1'b0;
  logic        rst, start, decrypt, abort, key_ready;
  logic [4:0]  rom_addr;
  logic [63:0] rom_q;
  logic        key_valid;
  logic [31:0] key_a, key_b;
  logic [4:0]  key_round;
  logic [1:0]  key_phase;
  logic        busy, done;

  logic [63:0] rom [NP];
  int total = 0;
  int bad   = 0;

  assign rom_q = (rom_addr < 5'd22) ? rom[rom_addr] : 64'h0;

  rc6_key_sequencer #(.W(32), .PAIRS(22)) dut (
    .clk(clk), .rst(rst), .start(start), .decrypt(decrypt), .abort(abort),
    .rom_addr(rom_addr), .rom_q(rom_q), .key_valid(key_valid), .key_ready(key_ready),
    .key_a(key_a), .key_b(key_b), .key_round(key_round), .key_phase(key_phase),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // k-th pair presented in a sequence: index, words and role from the ROM model.
  task automatic chk_pair(input bit dec, input int k);
    int idx;
    logic [1:0] ph;
    idx = dec ? (NP - 1 - k) : k;
    ph  = (idx == 0) ? 2'd0 : ((idx == NP - 1) ? 2'd2 : 2'd1);
    chk("key_a", key_a, rom[idx][31:0]);
    chk("key_b", key_b, rom[idx][63:32]);
    chk("key_round", key_round, idx);
    chk("key_phase", key_phase, ph);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_valid"}, key_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_key_a"}, key_a, 0);
    chk({tag, "_key_b"}, key_b, 0);
    chk({tag, "_round"}, key_round, 0);
    chk({tag, "_phase"}, key_phase, 0);
  endtask

  // mode: 0 ready always, 1 random ready, 2 three stall cycles at pair 5
  task automatic run_seq(input bit dec, input int mode, input int abort_at, input int pulse_at);
    int n, edges, stalls, done_edge;
    bit r, aborted;
    start = 1'b1; decrypt = dec; key_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_after_start", key_valid, 0);
    @(posedge clk); @(negedge clk);
    edges = 1; n = 0; stalls = 0; aborted = 1'b0; done_edge = -1;
    chk("first_valid", key_valid, 1);
    chk_pair(dec, 0);
    while (n < NP && edges < 400 && !aborted) begin
      if (mode == 0) r = 1'b1;
      else if (mode == 1) r = 1'($urandom_range(0, 1));
      else r = !(n == 5 && stalls < 3);
      if (!r) stalls++;
      key_ready = r;
      abort = (n == abort_at) && r;
      start = (n == pulse_at);
      decrypt = (n == pulse_at) ? ~dec : dec;
      @(posedge clk); @(negedge clk);
      edges++;
      start = 1'b0; decrypt = dec;
      if (abort) begin
        abort = 1'b0;
        aborted = 1'b1;
        chk_cleared("abort");
      end else begin
        if (r) n++;
        if (n < NP) begin
          chk("run_valid", key_valid, 1);
          chk("run_busy", busy, 1);
          chk("run_done", done, 0);
          chk_pair(dec, n);
        end else begin
          chk("end_valid", key_valid, 0);
          chk("end_done", done, 1);
          chk("end_busy", busy, 0);
          done_edge = edges;
        end
      end
    end
    key_ready = 1'b0;
    if (!aborted) begin
      chk("completed_pairs", n, NP);
      chk("done_edge", done_edge, 23 + stalls);
    end
    @(posedge clk); @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", key_valid, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; abort = 1'b0; key_ready = 1'b0;
    for (int i = 0; i < NP; i++) rom[i] = {32'(2 * i + 1), 32'(2 * i)};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cleared("reset");
    chk("reset_rom_addr", rom_addr, 0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);

    run_seq(1'b0, 0, -1, -1);   // forward, ready high
    run_seq(1'b1, 0, -1, -1);   // reverse
    run_seq(1'b0, 2, -1, -1);   // backpressure at pair 5
    run_seq(1'b0, 0, 7, -1);    // abort at pair 7
    run_seq(1'b0, 0, -1, -1);   // restart begins at pair 0
    run_seq(1'b0, 0, -1, 10);   // start pulsed mid-run is ignored

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_valid", key_valid, 0);
    @(posedge clk); @(negedge clk);
    chk("start_abort_busy2", busy, 0);
    chk("start_abort_valid2", key_valid, 0);

    // reset mid-sequence in reverse: direction also returns to forward
    start = 1'b1; decrypt = 1'b1; key_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_valid", key_valid, 1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0; key_ready = 1'b0; decrypt = 1'b0;
    chk_cleared("midrst");
    chk("midrst_rom_addr", rom_addr, 0);
    @(posedge clk); @(negedge clk);
    chk("midrst_no_done", done, 0);

    // random ROM contents, direction and ready pattern
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NP; i++) rom[i] = {$urandom, $urandom};
      run_seq(1'($urandom_range(0, 1)), 1, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
